ex_muldiv_stage: RTL and testbench

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

---
 rtl/ex_muldiv_stage.sv | 212 +++++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage -- execute stage with single-cycle ALU ops and iterative MUL/DIVU/REMU.
//   i_clock, i_reset        : clock, asynchronous active-high reset
//   i_in_valid / o_in_ready : instruction handshake from decode
//   i_op                    : 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 MUL 6 DIVU 7 REMU
//   i_operand_a/b           : decode operands
//   i_fa_sel/i_fb_sel       : 0 = decode operand, k = forwarding slice k-1
//   i_fwd_data              : NUM_FWD packed forwarding values
//   i_rd_addr               : destination register, carried with the result
//   i_flush                 : kills in-flight and presented work
//   o_out_valid/i_out_ready : EX/MEM result handshake
//   o_out_result/o_out_rd_addr : registered result and destination
//   o_busy                  : iterative unit not idle
module ex_muldiv_stage #(
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned NUM_FWD = 2,
    localparam int unsigned FSEL_W  = $clog2(NUM_FWD + 1),
    localparam int unsigned CNT_W   = $clog2(XLEN + 1)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [2:0]              i_op,
    input  logic [XLEN-1:0]         i_operand_a,
    input  logic [XLEN-1:0]         i_operand_b,
    input  logic [FSEL_W-1:0]       i_fa_sel,
    input  logic [FSEL_W-1:0]       i_fb_sel,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    input  logic [4:0]              i_rd_addr,
    input  logic                    i_flush,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [XLEN-1:0]         o_out_result,
    output logic [4:0]              o_out_rd_addr,
    output logic                    o_busy
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIVU = 3'd6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    // MUL: r_a multiplicand (shifts left), r_b multiplier (shifts right), r_acc product.
    // DIV: r_a dividend shifting out / quotient shifting in, r_b divisor, r_acc remainder.
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_acc;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_result;
    logic [4:0]          r_out_rd_addr;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_is_iter;
    logic                w_done_load;
    logic [XLEN-1:0]     w_opa;
    logic [XLEN-1:0]     w_opb;
    logic [XLEN-1:0]     w_alu;
    logic [XLEN-1:0]     w_iter_result;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;

    // Forwarding mux; out-of-range selects fall back to the decode operand.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [FSEL_W-1:0]       sel,
        input logic [XLEN-1:0]         dec,
        input logic [NUM_FWD*XLEN-1:0] fwd
    );
        logic [XLEN-1:0] v;
        v = dec;
        for (int unsigned k = 1; k <= NUM_FWD; k++) begin
            if (sel == FSEL_W'(k)) begin
                v = fwd[(k-1)*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    // Handshake and operand selection.
    always_comb begin
        w_in_ready  = (r_state == S_IDLE) && (!r_out_valid || i_out_ready) && !i_reset;
        w_accept    = i_in_valid && w_in_ready && !i_flush;
        w_is_iter   = (i_op >= OP_MUL);
        w_done_load = (r_state == S_DONE) && (!r_out_valid || i_out_ready) && !i_flush;
        w_opa       = fwd_mux(i_fa_sel, i_operand_a, i_fwd_data);
        w_opb       = fwd_mux(i_fb_sel, i_operand_b, i_fwd_data);
    end

    // Single-cycle ALU.
    always_comb begin
        w_alu = '0;
        case (i_op)
            OP_ADD:  w_alu = w_opa + w_opb;
            OP_SUB:  w_alu = w_opa - w_opb;
            OP_AND:  w_alu = w_opa & w_opb;
            OP_OR:   w_alu = w_opa | w_opb;
            OP_XOR:  w_alu = w_opa ^ w_opb;
            default: w_alu = '0;
        endcase
    end

    // Restoring-division trial subtract; a clear borrow bit means the subtract fits.
    always_comb begin
        w_rem_sh = {r_acc, r_a[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        if (r_op == OP_MUL) begin
            w_iter_result = r_acc;
        end else if (r_op == OP_DIVU) begin
            w_iter_result = r_a;
        end else begin
            w_iter_result = r_acc;
        end
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_iter) w_state_nxt = S_BUSY;
            S_BUSY: if (r_cnt == LAST_STEP) w_state_nxt = S_DONE;
            S_DONE: if (w_done_load) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Iterative datapath: latch at accept, one step per BUSY edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_op  <= OP_ADD;
            r_rd  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (w_accept && w_is_iter) begin
            r_cnt <= '0;
            r_op  <= i_op;
            r_rd  <= i_rd_addr;
            r_a   <= w_opa;
            r_b   <= w_opb;
            r_acc <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op == OP_MUL) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end else begin
                r_a <= {r_a[XLEN-2:0], ~w_diff[XLEN]};
                r_acc <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            end
        end
    end

    // EX/MEM output register; retire and reload can share an edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd_addr <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_iter) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_alu;
            r_out_rd_addr <= i_rd_addr;
        end else if (w_done_load) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_iter_result;
            r_out_rd_addr <= r_rd;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_out_result  = r_out_result;
    assign o_out_rd_addr = r_out_rd_addr;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage (XLEN=32, NUM_FWD=2): directed cases with
// literal expectations plus randomized traffic checked against a transaction model.
module tb_ex_muldiv_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [1:0]  fa_sel;
    logic [1:0]  fb_sel;
    logic [63:0] fwd_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ex_muldiv_stage #(.XLEN(32), .NUM_FWD(2)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_op         (op),
        .i_operand_a  (operand_a),
        .i_operand_b  (operand_b),
        .i_fa_sel     (fa_sel),
        .i_fb_sel     (fb_sel),
        .i_fwd_data   (fwd_data),
        .i_rd_addr    (rd_addr),
        .i_flush      (flush),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_result (out_result),
        .o_out_rd_addr(out_rd_addr),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] dec,
                                         input logic [63:0] fwd);
        if (sel == 2'd1) return fwd[31:0];
        if (sel == 2'd2) return fwd[63:32];
        return dec;
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (o)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a * b;
            3'd6: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    bit          m_valid;
    logic [31:0] m_result;
    logic [4:0]  m_rd;
    bit          m_pending;
    int          m_wait;
    logic [31:0] m_pres;
    logic [4:0]  m_prd;
    bit          m_rdy;
    bit          m_acc;
    logic [31:0] m_r;

    // Transaction model: ALU ops land at the accept edge, iterative ops 33 edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   = 1'b0;
            m_result  = '0;
            m_rd      = '0;
            m_pending = 1'b0;
            m_wait    = 0;
        end else begin
            m_rdy = !m_pending && (!m_valid || out_ready);
            m_acc = in_valid && m_rdy && !flush;
            if (flush) begin
                m_valid   = 1'b0;
                m_pending = 1'b0;
            end else begin
                m_r = ref_op(op, pick(fa_sel, operand_a, fwd_data), pick(fb_sel, operand_b, fwd_data));
                if (m_acc && op < 3'd5) begin
                    m_valid  = 1'b1;
                    m_result = m_r;
                    m_rd     = rd_addr;
                end else if (m_pending && m_wait == 0 && (!m_valid || out_ready)) begin
                    m_valid   = 1'b1;
                    m_result  = m_pres;
                    m_rd      = m_prd;
                    m_pending = 1'b0;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
                if (m_pending && m_wait > 0) m_wait--;
                if (m_acc && op >= 3'd5) begin
                    m_pending = 1'b1;
                    m_wait    = 32;
                    m_pres    = m_r;
                    m_prd     = rd_addr;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, !rst && !m_pending && (!m_valid || out_ready));
            check("busy", busy, m_pending);
            check("out_valid", out_valid, m_valid);
            if (m_valid || rst) begin
                check("out_result", out_result, m_result);
                check("out_rd_addr", out_rd_addr, m_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [63:0] fwd, input logic [31:0] exp, input int exp_lat);
        logic [4:0] rd;
        int lat;
        rd        = 5'($urandom);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        fa_sel    = fa;
        fb_sel    = fb;
        fwd_data  = fwd;
        rd_addr   = rd;
        step();
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        fwd_data  = {$urandom, $urandom};
        rd_addr   = 5'($urandom);
        if (exp_lat > 0) check({name, " busy"}, busy, 1'b1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, out_result, exp);
        check({name, " rd"}, out_rd_addr, rd);
        check({name, " busy after"}, busy, 1'b0);
    endtask

    int seen;
    int mode;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        fa_sel    = '0;
        fb_sel    = '0;
        fwd_data  = '0;
        rd_addr   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #7;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_rd", out_rd_addr, 5'd0);
        check("reset busy", busy, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        run_op("ADD wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 64'd0, 32'd0, 0);
        run_op("SUB fwd", 3'd1, 32'd999, 32'd3, 2'd2, 2'd0, {32'd10, 32'd55}, 32'd7, 0);
        run_op("AND", 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 2'd3, 2'd0, 64'd0, 32'h00F0_1200, 0);
        run_op("XOR fwd", 3'd4, 32'd0, 32'd0, 2'd1, 2'd2, {32'hAAAA_0000, 32'h0000_5555}, 32'hAAAA_5555, 0);
        run_op("MUL big", 3'd5, 32'h0001_0000, 32'h0001_0000, 2'd0, 2'd0, 64'd0, 32'd0, 33);
        run_op("MUL 7x6", 3'd5, 32'd7, 32'd6, 2'd0, 2'd0, 64'd0, 32'd42, 33);
        run_op("MUL fwd", 3'd5, 32'd0, 32'd0, 2'd1, 2'd2, {32'd6, 32'd7}, 32'd42, 33);
        run_op("DIVU 100/7", 3'd6, 32'd100, 32'd7, 2'd0, 2'd0, 64'd0, 32'd14, 33);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 2'd0, 2'd0, 64'd0, 32'd2, 33);
        run_op("DIVU x/0", 3'd6, 32'h1234_5678, 32'd0, 2'd0, 2'd0, 64'd0, 32'hFFFF_FFFF, 33);
        run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 2'd0, 2'd0, 64'd0, 32'd5, 33);
        run_op("DIVU max", 3'd6, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 64'd0, 32'hFFFF_FFFF, 33);

        // Flush at BUSY cycle 10 together with a presented instruction.
        in_valid = 1'b1; op = 3'd5; operand_a = 32'd3; operand_b = 32'd4;
        fa_sel = 2'd0; fb_sel = 2'd0; rd_addr = 5'd9;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        flush = 1'b1; in_valid = 1'b1; op = 3'd0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush busy", busy, 1'b0);
        check("flush out_valid", out_valid, 1'b0);
        seen = 0;
        repeat (40) begin step(); if (out_valid) seen++; end
        check("flush no result", seen, 0);

        // Asynchronous reset in the middle of a divide.
        in_valid = 1'b1; op = 3'd6; operand_a = 32'd100; operand_b = 32'd7; rd_addr = 5'd17;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("areset busy", busy, 1'b0);
        check("areset out_valid", out_valid, 1'b0);
        check("areset out_result", out_result, 32'd0);
        check("areset out_rd", out_rd_addr, 5'd0);
        check("areset in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        seen = 0;
        repeat (40) begin step(); if (out_valid) seen++; end
        check("areset no result", seen, 0);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            op        = 3'($urandom_range(0, 7));
            mode      = $urandom_range(0, 9);
            operand_a = (mode < 3) ? 32'($urandom_range(0, 15)) : $urandom;
            operand_b = (mode == 0) ? 32'd0 : ((mode < 4) ? 32'($urandom_range(0, 15)) : $urandom);
            fa_sel    = 2'($urandom_range(0, 3));
            fb_sel    = 2'($urandom_range(0, 3));
            fwd_data  = {$urandom, $urandom};
            rd_addr   = 5'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 2);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
